seq_adder_nb: RTL and testbench
===============================

Name: seq_adder_nb

Overview:
- Parametrised multi-cycle ripple adder/subtractor. Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, using a registered carry between digits.
- Generalises the team's 1-bit full adder cell to N bits, adding a subtract mode, an overflow flag and a start/done handshake.
- Used where area matters more than latency, such as accumulators and slow datapaths under a controller FSM.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1).
- DIGIT, 1, bits processed per cycle. Must divide WIDTH; an illegal value is an elaboration error.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  operand A, sampled with start.
- b  input  WIDTH  operand B, sampled with start.
- cin  input  1  carry-in, sampled with start.
- sub  input  1  0: a+b+cin; 1: a-b-cin (computed as a+~b+~cin), sampled with start.
- busy  output  1  high while digits are being processed.
- done  output  1  one-cycle pulse when s/cout/ovf become valid.
- s  output  WIDTH  sum/difference.
- cout  output  1  add: carry-out; sub: 1 = no borrow (a >= b+cin, unsigned).
- ovf  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB).

Behaviour:
- Reset (rst=1 at a rising edge, any state): state=IDLE; busy=0, done=0, s=0, cout=0, ovf=0; internal shift registers, carry and digit counter cleared. Reset aborts an operation in progress; no done is produced for it.
- States: IDLE, RUN, DONE. N = WIDTH/DIGIT.
- IDLE: on start=1 at edge E0:
  - latch a -> opA;
  - latch (sub ? ~b : b) -> opB;
  - latch carry = cin XOR sub;
  - set count=0, busy=1, go RUN.
- RUN, each edge E1..EN:
  - ripple-add the DIGIT LSBs of opA, opB and carry;
  - shift opA and opB right by DIGIT;
  - shift the result digit into s from the MSB side;
  - carry <= digit carry-out; count++.
- At EN (count=N-1):
  - capture cout = final carry;
  - ovf = carry into bit WIDTH-1 XOR final carry;
  - busy <= 0, done <= 1, go DONE.
- Latency: done rises exactly N edges after the edge that sampled start. busy is high for exactly N cycles.
- DONE: lasts one cycle; done=1 only here.
  - start=1 here is accepted exactly as in IDLE: back-to-back operation, done drops, busy rises.
  - Otherwise go IDLE.
- start while busy=1 is ignored; the operation in flight is unaffected.
- a, b, cin and sub may change freely after the sampling edge.
- s is not valid while busy=1; it shifts during RUN. s, cout and ovf hold their values from DONE until the next accepted start or reset.
- Sub mode with cin=1 means subtract with borrow-in.
- WIDTH=1, DIGIT=1 degenerates to a registered 1-bit full adder with 1-cycle latency.
- Width rules: the result is modulo 2^WIDTH; no sign extension is performed internally.

Test Plan:
- WIDTH=1, DIGIT=1, all 8 {a,b,cin} combos with sub=0 -> s and cout match the full-adder truth table. Example: 1+1+1 -> s=1, cout=1. done follows 1 edge after start.
- WIDTH=8, DIGIT=1, sub=0:
  - a=0x3C, b=0x45, cin=0 -> s=0x81, cout=0, ovf=1; busy high 8 cycles, done on 8th edge.
  - a=0xFF, b=0x01 -> s=0x00, cout=1, ovf=0.
- WIDTH=8, sub=1:
  - a=0x05, b=0x07, cin=0 -> s=0xFE, cout=0, ovf=0.
  - a=0x80, b=0x01 -> s=0x7F, cout=1, ovf=1.
  - a=0x10, b=0x00, cin=1 -> s=0x0F, cout=1.
- WIDTH=16, DIGIT=4:
  - a=0xFFFF, b=0x0000, cin=1 -> s=0x0000, cout=1, ovf=0; done 4 edges after start.
  - Back-to-back start during DONE with a=0x1234, b=0x4321 -> s=0x5555, no idle cycle between the two operations.
- WIDTH=8, DIGIT=2:
  - Pulse start again and change a/b while busy -> ignored; the first result is unchanged.
  - rst=1 mid-RUN -> next cycle busy=0, done=0, s=0, cout=0, ovf=0, and no done pulse follows.
  - A new start after reset completes correctly.

Source files
------------

// File: rtl/seq_adder_nb.sv
// seq_adder_nb: multi-cycle ripple adder/subtractor, DIGIT bits per clock with a registered carry.
module seq_adder_nb #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);
  localparam int N  = (DIGIT > 0) ? WIDTH / DIGIT : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  if (DIGIT < 1 || WIDTH < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("seq_adder_nb: DIGIT must be >=1 and divide WIDTH");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t            state_q, state_d;
  logic [WIDTH-1:0]  opa_q, opa_d, opb_q, opb_d, s_q, s_d;
  logic              carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DIGIT:0]    dsum;
  logic [WIDTH+DIGIT-1:0] s_cat;
  logic              accept, last;
  always_comb begin
    dsum    = {1'b0, opa_q[DIGIT-1:0]} + {1'b0, opb_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    s_cat   = {dsum[DIGIT-1:0], s_q};
    accept  = start && (state_q != RUN);
    last    = (state_q == RUN) && (cnt_q == CW'(N - 1));
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    s_d     = s_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (accept) begin
      opa_d   = a;
      opb_d   = sub ? ~b : b;
      carry_d = cin ^ sub;
      cnt_d   = '0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      opa_d   = opa_q >> DIGIT;
      opb_d   = opb_q >> DIGIT;
      s_d     = s_cat[WIDTH+DIGIT-1:DIGIT];
      carry_d = dsum[DIGIT];
      cnt_d   = cnt_q + CW'(1);
      if (last) begin
        cout_d  = dsum[DIGIT];
        // carry into the MSB is recovered from its sum bit: c = a ^ b ^ s
        ovf_d   = opa_q[DIGIT-1] ^ opb_q[DIGIT-1] ^ dsum[DIGIT-1] ^ dsum[DIGIT];
        state_d = DONE;
      end
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_seq_adder_nb.sv
// tb_seq_adder_nb: scoreboard bench over four seq_adder_nb configurations.
module tb_seq_adder_nb;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  st, bs, dn, co, ov;
  logic [15:0] a, b;
  logic        cin, sub;
  logic        s1;
  logic [7:0]  s8, s82;
  logic [15:0] s16;
  logic [17:0] act [4];
  logic [17:0] q0[$], q1[$], q2[$], q3[$];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  seq_adder_nb #(.WIDTH(1), .DIGIT(1)) u_w1 (.clk(clk), .rst(rst), .start(st[0]), .a(a[0:0]), .b(b[0:0]),
    .cin(cin), .sub(sub), .busy(bs[0]), .done(dn[0]), .s(s1), .cout(co[0]), .ovf(ov[0]));
  seq_adder_nb #(.WIDTH(8), .DIGIT(1)) u_w8 (.clk(clk), .rst(rst), .start(st[1]), .a(a[7:0]), .b(b[7:0]),
    .cin(cin), .sub(sub), .busy(bs[1]), .done(dn[1]), .s(s8), .cout(co[1]), .ovf(ov[1]));
  seq_adder_nb #(.WIDTH(16), .DIGIT(4)) u_w16 (.clk(clk), .rst(rst), .start(st[2]), .a(a), .b(b),
    .cin(cin), .sub(sub), .busy(bs[2]), .done(dn[2]), .s(s16), .cout(co[2]), .ovf(ov[2]));
  seq_adder_nb #(.WIDTH(8), .DIGIT(2)) u_w8d2 (.clk(clk), .rst(rst), .start(st[3]), .a(a[7:0]), .b(b[7:0]),
    .cin(cin), .sub(sub), .busy(bs[3]), .done(dn[3]), .s(s82), .cout(co[3]), .ovf(ov[3]));

  assign act[0] = {15'd0, s1, co[0], ov[0]};
  assign act[1] = {8'd0, s8, co[1], ov[1]};
  assign act[2] = {s16, co[2], ov[2]};
  assign act[3] = {8'd0, s82, co[3], ov[3]};

  function automatic int qsize(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic logic [17:0] qpop(input int k);
    case (k)
      0: return q0.pop_front();
      1: return q1.pop_front();
      2: return q2.pop_front();
      default: return q3.pop_front();
    endcase
  endfunction

  function automatic void qpush(input int k, input logic [17:0] v);
    case (k)
      0: q0.push_back(v);
      1: q1.push_back(v);
      2: q2.push_back(v);
      default: q3.push_back(v);
    endcase
  endfunction

  // monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin : mon
    logic [17:0] e;
    for (int k = 0; k < 4; k++) begin
      if (dn[k]) begin
        checks++;
        if (qsize(k) == 0) begin
          errors++;
          $display("FAIL unexpected_done inst%0d got {s,cout,ovf}=%h required no done", k, act[k]);
        end else begin
          e = qpop(k);
          if (act[k] !== e) begin
            errors++;
            $display("FAIL result inst%0d got {s,cout,ovf}=%h required %h", k, act[k], e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int k, input logic [15:0] av, bv, input logic ci, sb,
                       input logic [17:0] ev, input bit push);
    a = av; b = bv; cin = ci; sub = sb;
    st[k] = 1'b1;
    if (push) qpush(k, ev);
    tick();
    st[k] = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
  endtask

  task automatic wait_done(input int k, input int n_exp);
    int n = 0, nb = 0;
    while (!dn[k] && n < 64) begin
      nb += int'(bs[k]);
      tick();
      n++;
    end
    checks++;
    if (!dn[k] || n != n_exp || nb != n_exp || bs[k]) begin
      errors++;
      $display("FAIL latency inst%0d got cycles=%0d busy_cycles=%0d done=%b required %0d", k, n, nb, dn[k], n_exp);
    end
  endtask

  task automatic check_idle(input int k, input string nm);
    checks++;
    if (bs[k] !== 1'b0 || dn[k] !== 1'b0 || act[k] !== 18'd0) begin
      errors++;
      $display("FAIL %s inst%0d got busy=%b done=%b {s,cout,ovf}=%h required 0 0 0", nm, k, bs[k], dn[k], act[k]);
    end
  endtask

  initial begin
    logic [7:0] fs, fc, fo;
    fs = 8'b1001_0110; fc = 8'b1110_1000; fo = 8'b0100_0010;
    rst = 1'b1; st = '0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) tick();
    for (int k = 0; k < 4; k++) check_idle(k, "reset");
    rst = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      issue(0, {15'd0, i[2]}, {15'd0, i[1]}, i[0], 1'b0, {15'd0, fs[i], fc[i], fo[i]}, 1);
      wait_done(0, 1);
      tick();
    end
    issue(1, 16'h3C, 16'h45, 0, 0, {16'h0081, 1'b0, 1'b1}, 1); wait_done(1, 8); tick();
    issue(1, 16'hFF, 16'h01, 0, 0, {16'h0000, 1'b1, 1'b0}, 1); wait_done(1, 8); tick();
    issue(1, 16'h05, 16'h07, 0, 1, {16'h00FE, 1'b0, 1'b0}, 1); wait_done(1, 8); tick();
    issue(1, 16'h80, 16'h01, 0, 1, {16'h007F, 1'b1, 1'b1}, 1); wait_done(1, 8); tick();
    issue(1, 16'h10, 16'h00, 1, 1, {16'h000F, 1'b1, 1'b0}, 1); wait_done(1, 8);
    repeat (3) tick();
    checks++;
    if (act[1] !== {16'h000F, 1'b1, 1'b0} || dn[1] !== 1'b0) begin
      errors++;
      $display("FAIL hold inst1 got {s,cout,ovf}=%h done=%b required %h 0", act[1], dn[1], {16'h000F, 1'b1, 1'b0});
    end
    issue(2, 16'hFFFF, 16'h0000, 1, 0, {16'h0000, 1'b1, 1'b0}, 1);
    wait_done(2, 4);
    issue(2, 16'h1234, 16'h4321, 0, 0, {16'h5555, 1'b0, 1'b0}, 1);
    checks++;
    if (dn[2] !== 1'b0 || bs[2] !== 1'b1) begin
      errors++;
      $display("FAIL back_to_back inst2 got done=%b busy=%b required 0 1", dn[2], bs[2]);
    end
    wait_done(2, 4); tick();
    issue(2, 16'h0000, 16'h0001, 0, 1, {16'hFFFF, 1'b0, 1'b0}, 1); wait_done(2, 4); tick();
    issue(3, 16'h3C, 16'h45, 0, 0, {16'h0081, 1'b0, 1'b1}, 1);
    tick();
    st[3] = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
    repeat (2) tick();
    st[3] = 1'b0;
    wait_done(3, 1);
    repeat (6) tick();
    issue(3, 16'h12, 16'h34, 0, 0, 18'd0, 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle(3, "abort_reset");
    repeat (8) tick();
    issue(3, 16'h7F, 16'h01, 0, 0, {16'h0080, 1'b0, 1'b1}, 1);
    wait_done(3, 4);
    repeat (3) tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (qsize(k) != 0) begin
        errors++;
        $display("FAIL pending inst%0d got %0d outstanding results required 0", k, qsize(k));
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
